// File: rtl/i_ap_err_corrector.sv
// Exact-sum rebuilder for the segmented approximate adder: finds each dropped
// inter-segment carry and patches the approximate sum one segment per cycle.
module i_ap_err_corrector #(
    parameter int WIDTH = 16,
    parameter int BASE  = 4,
    parameter int SEG   = 2,
    localparam int NSEG = (WIDTH - BASE) / SEG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] SUM_AP,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic [NSEG-1:0]  ERR_MASK,
    output logic [2:0]       ERR_CNT
);

    localparam int J0 = BASE - SEG;
    localparam int PW = $clog2(WIDTH) + 1;
    localparam int KW = (NSEG > 1) ? $clog2(NSEG) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] a_r, b_r;
    logic             carry;
    logic [KW-1:0]    idx;

    logic [PW-1:0]    wpos, spos;
    logic [SEG-1:0]   wa, wb, ta, tb, seg_fix;
    logic [SEG:0]     wsum, tsum;
    logic             g, p, err, c_nx, cout_nx, last;
    logic [J0:0]      c0sum;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = SCAN;
            end
            SCAN: begin
                if (last) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Window for segment idx+1 sits just below it; segment starts at spos.
    always_comb begin
        wpos    = PW'(J0) + PW'(SEG) * PW'(idx);
        spos    = wpos + PW'(SEG);
        wa      = a_r[wpos +: SEG];
        wb      = b_r[wpos +: SEG];
        wsum    = {1'b0, wa} + {1'b0, wb};
        g       = wsum[SEG];
        p       = &(wa ^ wb);
        err     = p & ~g & carry;
        c_nx    = g | (p & carry);
        seg_fix = SUM[spos +: SEG] + SEG'(err);
        ta      = a_r[WIDTH-1 -: SEG];
        tb      = b_r[WIDTH-1 -: SEG];
        tsum    = {1'b0, ta} + {1'b0, tb};
        cout_nx = tsum[SEG] | ((&(ta ^ tb)) & c_nx);
        last    = (idx == KW'(NSEG - 1));
        c0sum   = {1'b0, A[J0-1:0]} + {1'b0, B[J0-1:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r      <= '0;
            b_r      <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            SUM      <= '0;
            COUT     <= 1'b0;
            ERR_MASK <= '0;
            ERR_CNT  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r      <= A;
                        b_r      <= B;
                        SUM      <= SUM_AP;
                        carry    <= c0sum[J0];
                        idx      <= '0;
                        COUT     <= 1'b0;
                        ERR_MASK <= '0;
                        ERR_CNT  <= '0;
                    end
                end
                SCAN: begin
                    SUM[spos +: SEG] <= seg_fix;
                    ERR_MASK[idx]    <= err;
                    ERR_CNT          <= ERR_CNT + 3'(err);
                    carry            <= c_nx;
                    idx              <= idx + KW'(1);
                    if (last) COUT <= cout_nx;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i_ap_err_corrector.sv
// Directed and model-driven checks for the approximate-sum corrector.
module tb_i_ap_err_corrector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] A = '0, B = '0, SUM_AP = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] SUM;
    logic        COUT;
    logic [5:0]  ERR_MASK;
    logic [2:0]  ERR_CNT;

    int nchk = 0;
    int nerr = 0;

    i_ap_err_corrector dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .SUM_AP(SUM_AP),
        .out_valid(out_valid), .out_ready(out_ready),
        .SUM(SUM), .COUT(COUT),
        .ERR_MASK(ERR_MASK), .ERR_CNT(ERR_CNT)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] approx(input logic [15:0] a,
                                           input logic [15:0] b);
        int r, pos, w, spec, sg;
        r = (int'(a) + int'(b)) & 'hF;
        for (int k = 1; k <= 6; k++) begin
            pos  = 4 + 2 * (k - 1);
            w    = pos - 2;
            spec = (((a >> w) & 3) + ((b >> w) & 3)) >> 2;
            sg   = (((a >> pos) & 3) + ((b >> pos) & 3) + spec) & 3;
            r    = r | (sg << pos);
        end
        return r[15:0];
    endfunction

    function automatic logic [5:0] drop_mask(input logic [15:0] a,
                                             input logic [15:0] b);
        int pos, w, spec, tc, msk;
        logic [5:0] m;
        m = '0;
        for (int k = 1; k <= 6; k++) begin
            pos  = 4 + 2 * (k - 1);
            w    = pos - 2;
            msk  = (1 << pos) - 1;
            spec = (((a >> w) & 3) + ((b >> w) & 3)) >> 2;
            tc   = ((int'(a) & msk) + (int'(b) & msk)) >> pos;
            m[k-1] = (tc[0] == 1'b1) && (spec == 0);
        end
        return m;
    endfunction

    task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] ap);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("start_ready", in_ready, 1);
        A = a;
        B = b;
        SUM_AP = ap;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    int lat;
    logic [15:0] ra, rb;
    logic [16:0] ex;
    logic [5:0]  em;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", in_ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_sum", SUM, 0);
        chk("rst_mask", ERR_MASK, 0);
        chk("rst_cnt", ERR_CNT, 0);
        chk("rst_cout", COUT, 0);
        rst = 1'b0;
        @(negedge clk);

        start_op(16'h000F, 16'h0001, 16'h0000);
        wait_out(lat);
        chk("v1_lat", lat, 6);
        chk("v1_sum", SUM, 16'h0010);
        chk("v1_mask", ERR_MASK, 6'b000001);
        chk("v1_cnt", ERR_CNT, 1);
        chk("v1_cout", COUT, 0);
        release_out();

        start_op(16'h1234, 16'h4321, 16'h5555);
        wait_out(lat);
        chk("v2_lat", lat, 6);
        chk("v2_sum", SUM, 16'h5555);
        chk("v2_mask", ERR_MASK, 0);
        chk("v2_cnt", ERR_CNT, 0);
        chk("v2_cout", COUT, 0);
        release_out();

        start_op(16'hFFFF, 16'h0001, 16'hFFF0);
        wait_out(lat);
        chk("v3_valid", out_valid, 1);
        chk("v3_sum", SUM, 16'h0000);
        chk("v3_mask", ERR_MASK, 6'b111111);
        chk("v3_cnt", ERR_CNT, 6);
        chk("v3_cout", COUT, 1);
        release_out();

        start_op(16'h000F, 16'h0001, 16'h0000);
        wait_out(lat);
        chk("hold_start", out_valid, 1);
        A = 16'h1234;
        B = 16'h4321;
        SUM_AP = 16'h5555;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_ready", in_ready, 0);
            chk("hold_sum", SUM, 16'h0010);
            chk("hold_mask", ERR_MASK, 6'b000001);
        end
        in_valid = 1'b0;
        release_out();
        chk("rel_ready", in_ready, 1);
        chk("rel_valid", out_valid, 0);
        chk("rel_sum", SUM, 16'h0010);
        start_op(16'h1234, 16'h4321, 16'h5555);
        wait_out(lat);
        chk("next_lat", lat, 6);
        chk("next_sum", SUM, 16'h5555);
        chk("next_mask", ERR_MASK, 0);
        release_out();

        start_op(16'hFFFF, 16'h0001, 16'hFFF0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mrst_valid", out_valid, 0);
        chk("mrst_sum", SUM, 0);
        chk("mrst_mask", ERR_MASK, 0);
        chk("mrst_cnt", ERR_CNT, 0);
        chk("mrst_cout", COUT, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_ready", in_ready, 1);
        chk("mrst_valid2", out_valid, 0);

        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i == 0) begin
                ra = 16'hAAAA;
                rb = 16'h5556;
            end
            ex = {1'b0, ra} + {1'b0, rb};
            em = drop_mask(ra, rb);
            start_op(ra, rb, approx(ra, rb));
            wait_out(lat);
            chk("rnd_lat", lat, 6);
            chk("rnd_sum", SUM, ex[15:0]);
            chk("rnd_cout", COUT, ex[16]);
            chk("rnd_mask", ERR_MASK, em);
            chk("rnd_cnt", ERR_CNT, $countones(em));
            release_out();
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
